buzzer_seq: RTL and testbench
=============================

# buzzer_seq

Event-driven tone sequencer that sits directly upstream of the buzzer tone generator and drives its one-hot `buzzer_en[3:0]` select. Game logic raises single-cycle event pulses, and this block plays a short fixed pattern of tone/silence steps with millisecond durations. It arbitrates between events by priority and reports activity to the system.

## Interface
Parameters:
- `TICK_DIV`, default 100000: clock cycles per 1 ms duration tick (100 MHz clock). Legal range is ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `evt`  in  3  event pulses, one cycle each. `evt[2]` = game over, `evt[1]` = score, `evt[0]` = hit.
- `mute`  in  1  level input. When high, `buzzer_en` is forced to `4'b0000`; sequencing continues unaffected.
- `buzzer_en`  out  4  tone select to the buzzer. Values are one-hot (`1000`, `0100`, `0010`, `0001`) or `0000` for silence. Registered.
- `busy`  out  1  high while a pattern is playing. Registered.
- `done`  out  1  one-cycle pulse when a pattern completes naturally. Registered.

## Operation
Pattern ROM is fixed, internal, and holds at most 4 steps per pattern. Each step is a {tone, ms} pair:
- P0 (hit): {`1000`, 50}
- P1 (score): {`1000`, 60}, {`0100`, 60}, {`0010`, 120}
- P2 (game over): {`0010`, 150}, {`0000`, 50}, {`0001`, 300}

FSM states:
- IDLE: `buzzer_en`=0, `busy`=0. Any `evt` bit moves to PLAY at step 0 of the selected pattern.
- PLAY: output the current step's tone and count ms ticks. When the step count is reached:
  - if a next step exists, advance the step index;
  - else go to DONE.
- DONE: single cycle. `done`=1, `busy`=0, `buzzer_en`=0. Then go to IDLE, or straight to PLAY if an event arrives in this cycle.

Arbitration:
- Simultaneous bits: the highest index wins and the other bits are dropped.
- Event during PLAY with priority ≥ the current pattern: abort the current pattern and restart at step 0 of the new pattern. No `done` pulse is generated for the aborted pattern.
- Event during PLAY with lower priority: ignored and not queued.

Counters:
- Prescaler runs 0..`TICK_DIV`-1. It is cleared on every step start, so tick phase is step-aligned.
- ms counter is 9 bits wide (max 511) and compares against the step duration.

`mute` gates only the output register's input. Timing, `busy` and `done` are unchanged by `mute`.

## Timing
- Reset (async, `rst`=0): `buzzer_en`=`0000`, `busy`=0, `done`=0. FSM goes to IDLE; step index, prescaler and ms counter clear.
- Event sampled at edge k: `buzzer_en` carries the step-0 tone and `busy`=1 from k+1. Latency is 1 cycle.
- Each step holds its tone for exactly ms × `TICK_DIV` cycles. Step-to-step transitions add no gap cycle.
- After the last step:
  - exactly one cycle with `done`=1, `busy`=0, `buzzer_en`=0;
  - P0 therefore gives `busy` high for 50·`TICK_DIV` cycles, then the `done` pulse.
- Preemption at edge k: the new step-0 tone appears at k+1, and counters restart at k+1.
- Reset asserted mid-pattern: outputs clear immediately (asynchronously). The pattern is not resumed after reset releases.
- `mute` takes effect on `buzzer_en` one cycle after it changes.

## Test plan
All scenarios use `TICK_DIV`=4.
- **Reset:** `rst`=0 mid-P2 → `buzzer_en`=0, `busy`=0, `done`=0 immediately. After release, the block stays IDLE with no events.
- **Single hit:** `evt`=`001` at cycle 0 → `buzzer_en`=`1000` for cycles 1..200, `done`=1 at cycle 201, `busy` high for cycles 1..200.
- **Score pattern:** `evt`=`010` → `1000` for 240 cycles, `0100` for 240, `0010` for 480, then the `done` pulse. Total `busy` time is 960 cycles.
- **Priority and simultaneity:**
  - `evt`=`111` → P2 plays: `0010` for 600, `0000` for 200, `0001` for 1200.
  - `evt`=`001` injected during P2 → ignored; P2 timing unchanged.
- **Preemption:** `evt[0]` then `evt[2]` 100 cycles later → `buzzer_en`=`0010` the cycle after `evt[2]`, and no `done` for P0. Also repeat the `evt[1]` mid-P1 case: P1 restarts at step 0.
- **Mute and DONE-cycle event:**
  - `mute`=1 during P1 → `buzzer_en`=0, `busy` and `done` timing identical to the unmuted run.
  - `evt[0]` in the DONE cycle → `done`=1 that cycle, `buzzer_en`=`1000` the next cycle.

Source files
------------

// File: rtl/buzzer_seq.sv
// Event-driven tone sequencer: plays short fixed tone/silence patterns on a
// one-hot buzzer select, arbitrating game events by priority.
module buzzer_seq #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] evt,
    input  logic       mute,
    output logic [3:0] buzzer_en,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MSW = 9;
    localparam int unsigned SW  = 2;
    localparam int unsigned TW  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Pattern ROM: pattern index equals event priority (0 hit, 1 score, 2 game over).
    function automatic logic [TW-1:0] step_tone(input logic [1:0] p, input logic [SW-1:0] s);
        logic [TW-1:0] t;
        t = '0;
        case ({p, s})
            4'b00_00: t = 4'b1000;
            4'b01_00: t = 4'b1000;
            4'b01_01: t = 4'b0100;
            4'b01_10: t = 4'b0010;
            4'b10_00: t = 4'b0010;
            4'b10_01: t = 4'b0000;
            4'b10_10: t = 4'b0001;
            default:  t = 4'b0000;
        endcase
        return t;
    endfunction

    function automatic logic [MSW-1:0] step_ms(input logic [1:0] p, input logic [SW-1:0] s);
        logic [MSW-1:0] m;
        m = 9'd1;
        case ({p, s})
            4'b00_00: m = 9'd50;
            4'b01_00: m = 9'd60;
            4'b01_01: m = 9'd60;
            4'b01_10: m = 9'd120;
            4'b10_00: m = 9'd150;
            4'b10_01: m = 9'd50;
            4'b10_10: m = 9'd300;
            default:  m = 9'd1;
        endcase
        return m;
    endfunction

    function automatic logic [SW-1:0] last_step(input logic [1:0] p);
        logic [SW-1:0] l;
        case (p)
            2'd0:    l = 2'd0;
            2'd1:    l = 2'd2;
            2'd2:    l = 2'd2;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    state_t          state;
    logic [1:0]      pat;
    logic [SW-1:0]   step;
    logic [PW-1:0]   presc;
    logic [MSW-1:0]  ms_cnt;

    logic [1:0]      evt_pat;
    logic [TW-1:0]   cur_tone;
    logic [MSW-1:0]  cur_ms;
    logic [TW-1:0]   nxt_tone;
    logic [TW-1:0]   start_tone;
    logic            tick;
    logic            step_end;
    logic            last;
    logic            start;

    // Event decode, current step lookup and step-end detection.
    always_comb begin
        evt_pat    = 2'd0;
        start      = 1'b0;
        if (evt[2]) begin
            evt_pat = 2'd2;
        end else if (evt[1]) begin
            evt_pat = 2'd1;
        end
        cur_tone   = step_tone(pat, step);
        cur_ms     = step_ms(pat, step);
        nxt_tone   = step_tone(pat, SW'(step + 2'd1));
        start_tone = step_tone(evt_pat, 2'd0);
        tick       = (presc == PW'(TICK_DIV - 1));
        step_end   = tick && (ms_cnt == MSW'(cur_ms - 9'd1));
        last       = (step == last_step(pat));
        case (state)
            S_IDLE:  start = |evt;
            S_DONE:  start = |evt;
            S_PLAY:  start = (|evt) && (evt_pat >= pat);
            default: start = 1'b0;
        endcase
    end

    // Sequencer FSM with registered outputs; mute only gates the tone register input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pat       <= 2'd0;
            step      <= '0;
            presc     <= '0;
            ms_cnt    <= '0;
            buzzer_en <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state     <= S_PLAY;
                pat       <= evt_pat;
                step      <= '0;
                presc     <= '0;
                ms_cnt    <= '0;
                busy      <= 1'b1;
                buzzer_en <= mute ? 4'b0000 : start_tone;
            end else begin
                case (state)
                    S_IDLE: begin
                        busy      <= 1'b0;
                        buzzer_en <= '0;
                    end
                    S_PLAY: begin
                        if (step_end) begin
                            presc  <= '0;
                            ms_cnt <= '0;
                            if (last) begin
                                state     <= S_DONE;
                                step      <= '0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                buzzer_en <= '0;
                            end else begin
                                step      <= SW'(step + 2'd1);
                                buzzer_en <= mute ? 4'b0000 : nxt_tone;
                            end
                        end else begin
                            presc     <= tick ? '0 : PW'(presc + 1'b1);
                            ms_cnt    <= tick ? MSW'(ms_cnt + 9'd1) : ms_cnt;
                            buzzer_en <= mute ? 4'b0000 : cur_tone;
                        end
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        buzzer_en <= '0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        buzzer_en <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_seq.sv
// Directed bench for buzzer_seq with TICK_DIV=4 (1 ms = 4 cycles).
module tb_buzzer_seq;

    logic       clk;
    logic       rst;
    logic [2:0] evt;
    logic       mute;
    logic [3:0] buzzer_en;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    buzzer_seq #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .evt       (evt),
        .mute      (mute),
        .buzzer_en (buzzer_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] v);
        evt = v;
        step_clk();
        evt = 3'b000;
    endtask

    // Counts consecutive busy cycles showing the given tone (bounded).
    task automatic run_len(input logic [3:0] tone, output int n);
        n = 0;
        while (buzzer_en === tone && busy === 1'b1 && n < 5000) begin
            n++;
            step_clk();
        end
    endtask

    task automatic test_reset();
        int n;
        checks++;
        if (buzzer_en !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got en=%b busy=%b done=%b exp 0000 0 0", buzzer_en, busy, done);
        end
        pulse(3'b100);
        repeat (300) step_clk();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (buzzer_en !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got en=%b busy=%b done=%b exp 0000 0 0", buzzer_en, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (20) begin
            step_clk();
            if (busy !== 1'b0 || buzzer_en !== 4'b0000 || done !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_idle got %0d active cycles exp 0", n);
        end
    endtask

    task automatic test_hit();
        int n;
        pulse(3'b001);
        checks++;
        if (buzzer_en !== 4'b1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_latency got en=%b busy=%b exp 1000 1", buzzer_en, busy);
        end
        run_len(4'b1000, n);
        checks++;
        if (n !== 200) begin
            errors++;
            $display("FAIL hit_len got %0d exp 200", n);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || buzzer_en !== 4'b0000) begin
            errors++;
            $display("FAIL hit_done got done=%b busy=%b en=%b exp 1 0 0000", done, busy, buzzer_en);
        end
        step_clk();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_done_width got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_score();
        int n;
        pulse(3'b010);
        run_len(4'b1000, n);
        checks++;
        if (n !== 240) begin
            errors++;
            $display("FAIL score_s0 got %0d exp 240", n);
        end
        run_len(4'b0100, n);
        checks++;
        if (n !== 240) begin
            errors++;
            $display("FAIL score_s1 got %0d exp 240", n);
        end
        run_len(4'b0010, n);
        checks++;
        if (n !== 480) begin
            errors++;
            $display("FAIL score_s2 got %0d exp 480", n);
        end
        checks++;
        if (done !== 1'b1 || buzzer_en !== 4'b0000) begin
            errors++;
            $display("FAIL score_done got done=%b en=%b exp 1 0000", done, buzzer_en);
        end
        repeat (3) step_clk();
    endtask

    task automatic test_priority();
        int n;
        pulse(3'b111);
        checks++;
        if (buzzer_en !== 4'b0010) begin
            errors++;
            $display("FAIL prio_111 got %b exp 0010", buzzer_en);
        end
        repeat (100) step_clk();
        pulse(3'b001);
        run_len(4'b0010, n);
        checks++;
        if (n !== 499) begin
            errors++;
            $display("FAIL prio_ignore_s0 got %0d exp 499", n);
        end
        run_len(4'b0000, n);
        checks++;
        if (n !== 200) begin
            errors++;
            $display("FAIL prio_s1_silence got %0d exp 200", n);
        end
        run_len(4'b0001, n);
        checks++;
        if (n !== 1200) begin
            errors++;
            $display("FAIL prio_s2 got %0d exp 1200", n);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL prio_done got %b exp 1", done);
        end
        repeat (3) step_clk();
        pulse(3'b011);
        run_len(4'b1000, n);
        checks++;
        if (n !== 240 || buzzer_en !== 4'b0100) begin
            errors++;
            $display("FAIL prio_011 got len=%0d en=%b exp 240 0100", n, buzzer_en);
        end
        run_len(4'b0100, n);
        run_len(4'b0010, n);
        repeat (3) step_clk();
    endtask

    task automatic test_preempt();
        int n;
        pulse(3'b001);
        repeat (99) step_clk();
        pulse(3'b100);
        checks++;
        if (buzzer_en !== 4'b0010 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL preempt_p2 got en=%b done=%b busy=%b exp 0010 0 1", buzzer_en, done, busy);
        end
        run_len(4'b0010, n);
        checks++;
        if (n !== 600) begin
            errors++;
            $display("FAIL preempt_p2_len got %0d exp 600", n);
        end
        run_len(4'b0000, n);
        run_len(4'b0001, n);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL preempt_done got %b exp 1", done);
        end
        repeat (3) step_clk();
        pulse(3'b010);
        repeat (299) step_clk();
        checks++;
        if (buzzer_en !== 4'b0100) begin
            errors++;
            $display("FAIL restart_mid got %b exp 0100", buzzer_en);
        end
        pulse(3'b010);
        run_len(4'b1000, n);
        checks++;
        if (n !== 240) begin
            errors++;
            $display("FAIL restart_s0 got %0d exp 240", n);
        end
        run_len(4'b0100, n);
        run_len(4'b0010, n);
        checks++;
        if (n !== 480 || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_end got len=%0d done=%b exp 480 1", n, done);
        end
        repeat (3) step_clk();
    endtask

    task automatic test_mute_done_evt();
        int n;
        mute = 1'b1;
        pulse(3'b010);
        run_len(4'b0000, n);
        checks++;
        if (n !== 960) begin
            errors++;
            $display("FAIL mute_busy got %0d exp 960", n);
        end
        checks++;
        if (done !== 1'b1 || buzzer_en !== 4'b0000) begin
            errors++;
            $display("FAIL mute_done got done=%b en=%b exp 1 0000", done, buzzer_en);
        end
        mute = 1'b0;
        repeat (3) step_clk();
        pulse(3'b001);
        repeat (9) step_clk();
        mute = 1'b1;
        #1;
        checks++;
        if (buzzer_en !== 4'b1000) begin
            errors++;
            $display("FAIL mute_lag got %b exp 1000", buzzer_en);
        end
        step_clk();
        checks++;
        if (buzzer_en !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mute_on got en=%b busy=%b exp 0000 1", buzzer_en, busy);
        end
        mute = 1'b0;
        step_clk();
        run_len(4'b1000, n);
        checks++;
        if (n !== 189 || done !== 1'b1) begin
            errors++;
            $display("FAIL mute_off got len=%0d done=%b exp 189 1", n, done);
        end
        evt = 3'b001;
        step_clk();
        evt = 3'b000;
        checks++;
        if (buzzer_en !== 4'b1000 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_evt got en=%b busy=%b done=%b exp 1000 1 0", buzzer_en, busy, done);
        end
        run_len(4'b1000, n);
        checks++;
        if (n !== 200 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_evt_len got len=%0d done=%b exp 200 1", n, done);
        end
        repeat (3) step_clk();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        evt    = 3'b000;
        mute   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step_clk();
        test_reset();
        test_hit();
        test_score();
        test_priority();
        test_preempt();
        test_mute_done_evt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
